// File: rtl/lifo_arb_pkg.sv
// lifo_arb_pkg: shared FSM encoding and request op codes for lifo_arbiter.
package lifo_arb_pkg;
  typedef enum logic [1:0] {RUN, FLUSH, SETTLE} arb_state_t;
  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP = 1'b1;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first requester at or after ptr wins.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx,
  output logic           any
);
  logic [IDW-1:0] c;
  always_comb begin
    grant = '0;
    idx = '0;
    any = 1'b0;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = IDW'((int'(ptr) + i) % N);
      if (!any && req[c]) begin
        any = 1'b1;
        grant[c] = 1'b1;
        idx = c;
      end
    end
  end
endmodule

// File: rtl/lifo_arbiter.sv
// lifo_arbiter: round-robin sharing of one lifo between N_CLIENTS push/pop requesters.
// Optional statistics ports are enabled by defining LIFO_ARB_STATS_EN.
module lifo_arbiter
  import lifo_arb_pkg::*;
#(
  parameter int N_CLIENTS = 4,
  parameter int DWIDTH = 8,
  localparam int IDW = $clog2(N_CLIENTS)
) (
  input  logic                        clk_i,
  input  logic                        arst_n_i,
  input  logic                        arb_en_i,
  input  logic                        flush_i,
  input  logic [N_CLIENTS-1:0]        req_valid_i,
  input  logic [N_CLIENTS-1:0]        req_op_i,
  input  logic [N_CLIENTS*DWIDTH-1:0] req_data_i,
  output logic [N_CLIENTS-1:0]        req_ready_o,
  output logic                        rsp_valid_o,
  output logic [IDW-1:0]              rsp_id_o,
  output logic [DWIDTH-1:0]           rsp_data_o,
  output logic                        busy_o,
  output logic                        lifo_srst_o,
  output logic                        lifo_wrreq_o,
  output logic                        lifo_rdreq_o,
  output logic [DWIDTH-1:0]           lifo_data_o,
  input  logic [DWIDTH-1:0]           lifo_q_i,
  input  logic                        lifo_empty_i,
  input  logic                        lifo_full_i
`ifdef LIFO_ARB_STATS_EN
  ,
  output logic [15:0]                 stat_push_cnt_o,
  output logic [15:0]                 stat_pop_cnt_o,
  output logic                        stat_block_o
`endif
);
  arb_state_t state;
  logic [IDW-1:0] rr_ptr, gidx;
  logic [N_CLIENTS-1:0] elig, grant;
  logic any, push, pop, open;
  assign elig = req_valid_i & ((req_op_i & {N_CLIENTS{!lifo_empty_i}}) |
                               (~req_op_i & {N_CLIENTS{!lifo_full_i}}));
  // arst_n_i gates grants so no lifo strobe escapes while reset is held
  assign open = state == RUN && arb_en_i && arst_n_i;
  rr_arbiter #(.N(N_CLIENTS)) u_rr (
    .req  (elig & {N_CLIENTS{open}}),
    .ptr  (rr_ptr),
    .grant(grant),
    .idx  (gidx),
    .any  (any)
  );
  assign req_ready_o = grant;
  assign push = any && req_op_i[gidx] == OP_PUSH;
  assign pop = any && req_op_i[gidx] == OP_POP;
  assign lifo_wrreq_o = push;
  assign lifo_rdreq_o = pop;
  assign lifo_data_o = push ? req_data_i[int'(gidx)*DWIDTH +: DWIDTH] : '0;
  assign rsp_data_o = lifo_q_i;
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state <= RUN;
      rr_ptr <= '0;
      rsp_valid_o <= 1'b0;
      rsp_id_o <= '0;
      busy_o <= 1'b0;
      lifo_srst_o <= 1'b0;
    end else begin
      rsp_valid_o <= pop;
      if (pop) rsp_id_o <= gidx;
      if (any) rr_ptr <= gidx == IDW'(N_CLIENTS - 1) ? '0 : gidx + 1'b1;
      case (state)
        RUN: if (flush_i) begin
          state <= FLUSH;
          busy_o <= 1'b1;
          lifo_srst_o <= 1'b1;
        end
        FLUSH: begin
          state <= SETTLE;
          lifo_srst_o <= 1'b0;
        end
        default: begin
          state <= RUN;
          busy_o <= 1'b0;
        end
      endcase
    end
  end
`ifdef LIFO_ARB_STATS_EN
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      stat_push_cnt_o <= '0;
      stat_pop_cnt_o <= '0;
      stat_block_o <= 1'b0;
    end else begin
      stat_push_cnt_o <= state == FLUSH ? '0 :
                         (push && stat_push_cnt_o != '1) ? stat_push_cnt_o + 1'b1 : stat_push_cnt_o;
      stat_pop_cnt_o <= state == FLUSH ? '0 :
                        (pop && stat_pop_cnt_o != '1) ? stat_pop_cnt_o + 1'b1 : stat_pop_cnt_o;
      stat_block_o <= |(req_valid_i & ~elig);
    end
  end
`else
`endif
endmodule

// File: tb/tb_lifo_arbiter.sv
// tb_lifo_arbiter: directed plus random checks of lifo_arbiter against a queue-based reference.
module tb_lifo_arbiter;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic arb_en = 1'b0;
  logic flush = 1'b0;
  logic [3:0] valid = '0;
  logic [3:0] op = '0;
  logic [31:0] data = '0;
  logic [3:0] req_ready;
  logic rsp_valid, busy, lifo_srst, lifo_wrreq, lifo_rdreq;
  logic [1:0] rsp_id;
  logic [7:0] rsp_data, lifo_data;
  logic [7:0] lifo_q = '0;
  logic lifo_empty, lifo_full;
  logic [7:0] mem [16];
  int cnt = 0;
  int viol = 0;
  int nchk = 0;
  int nerr = 0;
  int m_rr = 0;
  int m_st = 0;
  int m_rsp_v = 0;
  int m_rsp_id = 0;
  int last_g = -1;
  logic [7:0] m_rsp_d = '0;
  logic [7:0] ref_q [$];
  logic [3:0] obs_ready;
  logic obs_wr, obs_srst, obs_busy;

  always #5 clk = ~clk;

  lifo_arbiter #(.N_CLIENTS(4), .DWIDTH(8)) dut (
    .clk_i(clk), .arst_n_i(arst_n), .arb_en_i(arb_en), .flush_i(flush),
    .req_valid_i(valid), .req_op_i(op), .req_data_i(data), .req_ready_o(req_ready),
    .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_data_o(rsp_data), .busy_o(busy),
    .lifo_srst_o(lifo_srst), .lifo_wrreq_o(lifo_wrreq), .lifo_rdreq_o(lifo_rdreq),
    .lifo_data_o(lifo_data), .lifo_q_i(lifo_q), .lifo_empty_i(lifo_empty), .lifo_full_i(lifo_full)
  );

  // depth-16 lifo with registered read data
  assign lifo_empty = cnt == 0;
  assign lifo_full = cnt == 16;
  always @(posedge clk) begin
    if ((lifo_wrreq && cnt == 16) || (lifo_rdreq && cnt == 0) || (lifo_wrreq && lifo_rdreq)) viol <= viol + 1;
    if (lifo_srst) cnt <= 0;
    else if (lifo_wrreq && cnt < 16) begin
      mem[cnt] <= lifo_data;
      cnt <= cnt + 1;
    end else if (lifo_rdreq && cnt > 0) begin
      lifo_q <= mem[cnt-1];
      cnt <= cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock cycle: predict, compare, advance reference on the edge
  task automatic step(input bit drop);
    int g;
    logic [3:0] er;
    logic [7:0] ed;
    bit ew, erd;
    #1;
    g = -1;
    if (m_st == 0 && arb_en)
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_rr + k) % 4;
        if (g < 0 && valid[c] && (op[c] ? ref_q.size() > 0 : ref_q.size() < 16)) g = c;
      end
    er = '0; ew = 1'b0; erd = 1'b0; ed = '0;
    if (g >= 0) begin
      er[g] = 1'b1;
      ew = !op[g];
      erd = op[g];
      if (ew) ed = data[g*8 +: 8];
    end
    obs_ready = req_ready; obs_wr = lifo_wrreq; obs_srst = lifo_srst; obs_busy = busy;
    chk("ready", 32'(req_ready), 32'(er));
    chk("wrreq", 32'(lifo_wrreq), 32'(ew));
    chk("rdreq", 32'(lifo_rdreq), 32'(erd));
    chk("lifo_data", 32'(lifo_data), 32'(ed));
    chk("busy", 32'(busy), 32'(m_st != 0));
    chk("srst", 32'(lifo_srst), 32'(m_st == 1));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_v));
    if (m_rsp_v != 0) begin
      chk("rsp_id", 32'(rsp_id), 32'(m_rsp_id));
      chk("rsp_data", 32'(rsp_data), 32'(m_rsp_d));
    end
    @(posedge clk);
    m_rsp_v = int'(erd);
    if (erd) begin
      m_rsp_id = g;
      m_rsp_d = ref_q.pop_back();
    end
    if (ew) ref_q.push_back(ed);
    if (g >= 0) m_rr = (g + 1) % 4;
    if (m_st == 1) ref_q.delete();
    m_st = m_st == 0 ? (flush ? 1 : 0) : (m_st == 1 ? 2 : 0);
    last_g = g;
    @(negedge clk);
    if (drop && g >= 0) valid[g] = 1'b0;
    flush = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    repeat (3) step(1);
  endtask

  initial begin
    int g0, srst_n, busy_n, gr_n;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_srst", 32'(lifo_srst), 0);
    chk("rst_ready", 32'(req_ready), 0);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    arb_en = 1'b1;
    // clients 0 and 2 push together, client 1 pops
    valid = 4'b0101; op = '0; data = 32'h00A2_00A0;
    step(1);
    chk("t1_first", 32'(obs_ready), 32'h1);
    step(1);
    chk("t1_second", 32'(obs_ready), 32'h4);
    valid = 4'b0010; op = 4'b0010;
    step(1);
    chk("t1_pop", 32'(obs_ready), 32'h2);
    chk("t1_rsp_valid", 32'(rsp_valid), 1);
    chk("t1_rsp_id", 32'(rsp_id), 1);
    chk("t1_rsp_data", 32'(rsp_data), 32'hA2);
    do_flush();
    // four continuous pushers fill the lifo in rotation starting at client 2
    valid = 4'b1111; op = '0; data = $urandom;
    for (int i = 0; i < 16; i++) begin
      step(0);
      chk("t2_rotate", 32'(obs_ready), 32'(1 << ((2 + i) % 4)));
      if (last_g >= 0) data[last_g*8 +: 8] = 8'($urandom);
    end
    step(0);
    chk("t2_full_ready", 32'(obs_ready), 0);
    chk("t2_full_wrreq", 32'(obs_wr), 0);
    // full: pop from client 1 goes first, then client 3 push
    valid = 4'b1010; op = 4'b0010;
    step(1);
    chk("t3_pop_first", 32'(obs_ready), 32'h2);
    step(1);
    chk("t3_push_next", 32'(obs_ready), 32'h8);
    do_flush();
    for (int i = 0; i < 5; i++) begin
      valid = 4'b0001; op = '0; data[7:0] = 8'($urandom);
      step(1);
    end
    // flush with 5 entries while clients keep pushing
    flush = 1'b1; valid = 4'b1111; op = '0;
    step(0);
    srst_n = 0; busy_n = 0; gr_n = 0;
    for (int i = 0; i < 2; i++) begin
      step(0);
      srst_n += int'(obs_srst);
      busy_n += int'(obs_busy);
      gr_n += int'(obs_ready != 0);
    end
    chk("t4_srst_cycles", 32'(srst_n), 1);
    chk("t4_busy_cycles", 32'(busy_n), 2);
    chk("t4_no_grants", 32'(gr_n), 0);
    chk("t4_empty", 32'(lifo_empty), 1);
    step(0);
    chk("t4_resume", 32'(obs_ready != 0), 1);
    valid = '0;
    do_flush();
    // pop on empty stalls until another client pushes
    valid = 4'b0001; op = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("t5_stall", 32'(obs_ready), 0);
    end
    valid[1] = 1'b1; op[1] = 1'b0; data[15:8] = 8'h5C;
    step(1);
    chk("t5_push", 32'(obs_ready), 32'h2);
    step(1);
    chk("t5_pop", 32'(obs_ready), 32'h1);
    chk("t5_rsp_id", 32'(rsp_id), 0);
    chk("t5_rsp_data", 32'(rsp_data), 32'h5C);
    // reset right after a pop grant
    valid = 4'b0001; op = '0; data[7:0] = 8'h33;
    step(1);
    valid = 4'b0001; op = 4'b0001;
    step(1);
    chk("t6_pre_rsp", 32'(rsp_valid), 1);
    valid = 4'b1111; op = '0;
    arst_n = 1'b0;
    #1;
    chk("t6_rsp_cleared", 32'(rsp_valid), 0);
    chk("t6_ready_forced", 32'(req_ready), 0);
    chk("t6_wrreq_forced", 32'(lifo_wrreq), 0);
    @(negedge clk);
    chk("t6_rsp_held", 32'(rsp_valid), 0);
    arst_n = 1'b1;
    m_rr = 0; m_st = 0; m_rsp_v = 0;
    step(1);
    chk("t6_ptr_zero", 32'(obs_ready), 32'h1);
    arb_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(0);
      chk("t6_arb_off", 32'(obs_ready), 0);
    end
    // random traffic with stable requests until accepted
    valid = '0;
    for (int i = 0; i < 600; i++) begin
      arb_en = $urandom_range(0, 9) != 0;
      flush = $urandom_range(0, 39) == 0;
      for (int c = 0; c < 4; c++)
        if (!valid[c] && $urandom_range(0, 2) == 0) begin
          valid[c] = 1'b1;
          op[c] = 1'($urandom);
          data[c*8 +: 8] = 8'($urandom);
        end
      step(1);
    end
    valid = '0;
    step(1);
    chk("lifo_protocol", 32'(viol), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
